// File: rtl/pipeline_stage_register_if.sv
// Handshake bundle for pipeline_stage_register.
//   in_valid / in_ready / in_data    : upstream offer and acceptance
//   out_valid / out_ready / out_data : head entry towards the downstream stage
// master: the environment (upstream producer plus downstream consumer).
// slave : the pipeline register itself.
interface pipeline_stage_register_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipeline_stage_register.sv
// Pipeline register between two datapath stages with valid/ready handshake,
// backpressure, synchronous flush and an optional skid entry.
//   clk       : rising-edge clock
//   reset     : synchronous, active-high; empties the stage
//   flush     : synchronous squash of all held entries (lower priority than reset)
//   bus       : pipeline_stage_register_if.slave (in_* upstream, out_* downstream)
//   occupancy : number of held entries (0..2)
// Build option: define PIPELINE_SKID_EN to add the skid entry. in_ready then
// comes from a flop instead of combinationally from out_ready; without it the
// stage holds a single entry and occupancy[1] is always 0.
module pipeline_stage_register #(
  parameter int unsigned      WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  pipeline_stage_register_if.slave    bus,
  output logic [1:0]                  occupancy
);

`ifdef PIPELINE_SKID_EN
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1, S_SKID = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             in_ready;
  logic             xfer_in;
  logic             xfer_out;

`ifdef PIPELINE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;

  // rdy_q mirrors (state != SKID). Masking with reset keeps in_ready low
  // while reset is held without delaying readiness after it drops.
  assign in_ready = rdy_q && !reset;
`else
  assign in_ready = !flush && ((state_q == S_EMPTY) || bus.out_ready);
`endif

  assign xfer_in  = bus.in_valid && in_ready;
  assign xfer_out = (state_q != S_EMPTY) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
`ifdef PIPELINE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = S_EMPTY;
      head_d  = RESET_VALUE;
`ifdef PIPELINE_SKID_EN
      skid_d  = RESET_VALUE;
`endif
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (xfer_in) begin
            state_d = S_FULL;
            head_d  = bus.in_data;
          end
        end
        S_FULL: begin
          if (xfer_in && xfer_out) begin
            head_d = bus.in_data;
          end else if (xfer_out) begin
            // Head returns to RESET_VALUE so no stale payload is visible.
            state_d = S_EMPTY;
            head_d  = RESET_VALUE;
`ifdef PIPELINE_SKID_EN
          end else if (xfer_in) begin
            state_d = S_SKID;
            skid_d  = bus.in_data;
`endif
          end
        end
`ifdef PIPELINE_SKID_EN
        S_SKID: begin
          if (xfer_out) begin
            state_d = S_FULL;
            head_d  = skid_q;
            skid_d  = RESET_VALUE;
          end
        end
`endif
        default: begin
          state_d = S_EMPTY;
          head_d  = RESET_VALUE;
        end
      endcase
    end
`ifdef PIPELINE_SKID_EN
    rdy_d = (state_d != S_SKID);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      head_q  <= RESET_VALUE;
`ifdef PIPELINE_SKID_EN
      skid_q  <= RESET_VALUE;
      rdy_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
`ifdef PIPELINE_SKID_EN
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q != S_EMPTY);
  assign bus.out_data  = head_q;

`ifdef PIPELINE_SKID_EN
  assign occupancy = (state_q == S_SKID) ? 2'd2 :
                     (state_q == S_FULL) ? 2'd1 : 2'd0;
`else
  assign occupancy = {1'b0, (state_q == S_FULL)};
`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
module tb_pipeline_stage_register;

`ifdef PIPELINE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk;
  logic reset;
  logic flush;
  logic [1:0] occ64, occ32, occ1;

  pipeline_stage_register_if #(.WIDTH(64)) bus64 ();
  pipeline_stage_register_if #(.WIDTH(32)) bus32 ();
  pipeline_stage_register_if #(.WIDTH(1))  bus1 ();

  pipeline_stage_register #(.WIDTH(64), .RESET_VALUE(64'h0)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus64), .occupancy(occ64)
  );
  pipeline_stage_register #(.WIDTH(32), .RESET_VALUE(32'hFFFF_FFFF)) u_w32 (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus32), .occupancy(occ32)
  );
  pipeline_stage_register #(.WIDTH(1), .RESET_VALUE(1'b1)) u_w1 (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus1), .occupancy(occ1)
  );

  // Narrow instances see the same traffic with truncated payloads.
  assign bus32.in_valid  = bus64.in_valid;
  assign bus32.in_data   = bus64.in_data[31:0];
  assign bus32.out_ready = bus64.out_ready;
  assign bus1.in_valid   = bus64.in_valid;
  assign bus1.in_data    = bus64.in_data[0];
  assign bus1.out_ready  = bus64.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held payloads, capacity 1 or 2.
  logic [63:0] mq[$];

  function automatic logic model_ready();
    if (SKID) return !reset && (mq.size() < 2);
    else      return !flush && ((mq.size() == 0) || bus64.out_ready);
  endfunction

  task automatic model_edge();
    bit pop, push;
    if (reset || flush) begin
      mq.delete();
    end else begin
      pop  = (mq.size() > 0) && bus64.out_ready;
      push = bus64.in_valid && model_ready();
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(bus64.in_data);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        fl;
    logic        v;
    logic [63:0] d;
    logic        ordy;
    logic        chk;
    logic        ov;
    logic [63:0] od;
    logic [1:0]  occ;
    logic        rdy;
  } vec_t;

  function automatic vec_t mk(int rst, int fl, int v, logic [63:0] d, int ordy,
                              int chk, int ov, logic [63:0] od, int occ, int rdy);
    vec_t r;
    r.rst  = (rst != 0);
    r.fl   = (fl != 0);
    r.v    = (v != 0);
    r.d    = d;
    r.ordy = (ordy != 0);
    r.chk  = (chk != 0);
    r.ov   = (ov != 0);
    r.od   = od;
    r.occ  = 2'(occ);
    r.rdy  = (rdy != 0);
    return r;
  endfunction

  task automatic drive(input logic rst, input logic fl, input logic v,
                       input logic [63:0] d, input logic ordy);
    reset          = rst;
    flush          = fl;
    bus64.in_valid = v;
    bus64.in_data  = d;
    bus64.out_ready = ordy;
  endtask

  // Expected values describe what is visible during the row's own cycle.
  task automatic apply(input vec_t t, input int idx);
    logic [31:0] e32;
    logic        e1;
    drive(t.rst, t.fl, t.v, t.d, t.ordy);
    @(negedge clk);
    if (t.chk) begin
      e32 = t.ov ? t.od[31:0] : 32'hFFFF_FFFF;
      e1  = t.ov ? t.od[0]    : 1'b1;
      cmp($sformatf("vec%0d_out_valid", idx), 64'(bus64.out_valid), 64'(t.ov));
      cmp($sformatf("vec%0d_out_data",  idx), bus64.out_data, t.od);
      cmp($sformatf("vec%0d_occupancy", idx), 64'(occ64), 64'(t.occ));
      cmp($sformatf("vec%0d_in_ready",  idx), 64'(bus64.in_ready), 64'(t.rdy));
      cmp($sformatf("vec%0d_w32_data",  idx), 64'(bus32.out_data), 64'(e32));
      cmp($sformatf("vec%0d_w1_data",   idx), 64'(bus1.out_data), 64'(e1));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);

    // Reset with a live offer, then stream 1..4 with out_ready held high.
    tbl.push_back(mk(1,0,1,64'hDEAD,0, 0, 0,64'h0,0,0));
    tbl.push_back(mk(1,0,1,64'hDEAD,0, 1, 0,64'h0,0,(SKID ? 0 : 1)));
    tbl.push_back(mk(0,0,1,64'h1,1,    1, 0,64'h0,0,1));
    tbl.push_back(mk(0,0,1,64'h2,1,    1, 1,64'h1,1,1));
    tbl.push_back(mk(0,0,1,64'h3,1,    1, 1,64'h2,1,1));
    tbl.push_back(mk(0,0,1,64'h4,1,    1, 1,64'h3,1,1));
    tbl.push_back(mk(0,0,0,64'h0,1,    1, 1,64'h4,1,1));
    tbl.push_back(mk(0,0,0,64'h0,1,    1, 0,64'h0,0,1));

    // Stall: upstream keeps offering each value until it is accepted.
`ifdef PIPELINE_SKID_EN
    tbl.push_back(mk(0,0,1,64'hA,0, 1, 0,64'h0,0,1));
    tbl.push_back(mk(0,0,1,64'hB,0, 1, 1,64'hA,1,1));
    tbl.push_back(mk(0,0,1,64'hC,0, 1, 1,64'hA,2,0));
    tbl.push_back(mk(0,0,1,64'hC,1, 1, 1,64'hA,2,0));
    tbl.push_back(mk(0,0,1,64'hC,1, 1, 1,64'hB,1,1));
`else
    tbl.push_back(mk(0,0,1,64'hA,0, 1, 0,64'h0,0,1));
    tbl.push_back(mk(0,0,1,64'hB,0, 1, 1,64'hA,1,0));
    tbl.push_back(mk(0,0,1,64'hB,0, 1, 1,64'hA,1,0));
    tbl.push_back(mk(0,0,1,64'hB,1, 1, 1,64'hA,1,1));
    tbl.push_back(mk(0,0,1,64'hC,1, 1, 1,64'hB,1,1));
`endif
    tbl.push_back(mk(0,0,0,64'h0,1, 1, 1,64'hC,1,1));
    tbl.push_back(mk(0,0,0,64'h0,1, 1, 0,64'h0,0,1));

    // Flush with both entries held (skid build) and a discarded offer 0x33.
    tbl.push_back(mk(0,0,1,64'h11,0, 1, 0,64'h0,0,1));
    tbl.push_back(mk(0,0,1,64'h22,0, 1, 1,64'h11,1,(SKID ? 1 : 0)));
    tbl.push_back(mk(0,1,1,64'h33,1, 1, 1,64'h11,(SKID ? 2 : 1),0));
    tbl.push_back(mk(0,0,0,64'h0,1,  1, 0,64'h0,0,1));
    tbl.push_back(mk(0,0,0,64'h0,1,  1, 0,64'h0,0,1));

    // Reset and flush together while FULL and stalled.
    tbl.push_back(mk(0,0,1,64'h55,0, 1, 0,64'h0,0,1));
    tbl.push_back(mk(1,1,1,64'h66,0, 1, 1,64'h55,1,0));
    tbl.push_back(mk(0,0,0,64'h0,1,  1, 0,64'h0,0,1));
    tbl.push_back(mk(0,0,0,64'h0,1,  1, 0,64'h0,0,1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Random traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] d, e_od;
      logic        e_ov;
      d = {$urandom(), $urandom()};
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 9) < 7), d, ($urandom_range(0, 9) < 6));
      @(negedge clk);
      e_ov = (mq.size() != 0);
      e_od = e_ov ? mq[0] : 64'h0;
      cmp("rnd_out_valid", 64'(bus64.out_valid), 64'(e_ov));
      cmp("rnd_out_data",  bus64.out_data, e_od);
      cmp("rnd_occupancy", 64'(occ64), 64'(mq.size()));
      cmp("rnd_in_ready",  64'(bus64.in_ready), 64'(model_ready()));
      cmp("rnd_w32_data",  64'(bus32.out_data), e_ov ? 64'(e_od[31:0]) : 64'hFFFF_FFFF);
      cmp("rnd_w1_data",   64'(bus1.out_data),  e_ov ? 64'(e_od[0]) : 64'h1);
      cmp("rnd_w32_occ",   64'(occ32), 64'(mq.size()));
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_register.md
# pipeline_stage_register

Parametrised pipeline register carrying a WIDTH-bit payload between two RISC-V datapath stages (e.g. IF/ID, ID/EX) under a valid/ready handshake. It adds backpressure, a synchronous flush for branch/exception squash, and an optional skid entry. The optional skid entry makes `in_ready` a pure register output, so long stall chains are not combinational paths. Latency is one clock edge from accepted input to visible output.

## Interface
- `WIDTH`, 64, payload width in bits (≥1)
- `RESET_VALUE`, {WIDTH{1'b0}}, value of `out_data` after reset or flush
- `clk` input 1 rising-edge clock
- `reset` input 1 reset, synchronous, active-high; clock `clk`
- `flush` input 1 synchronous squash of all held entries
- `in_valid` input 1 upstream offers `in_data`
- `in_ready` output 1 block accepts `in_data` this cycle
- `in_data` input WIDTH upstream payload
- `out_valid` output 1 `out_data` holds a valid entry
- `out_ready` input 1 downstream consumes `out_data` this cycle
- `out_data` output WIDTH head entry payload
- `occupancy` output 2 number of held entries (0..2)

## Operation
- Transfer in: `in_valid && in_ready` at a rising edge. Transfer out: `out_valid && out_ready` at a rising edge.
- Storage: main entry (head, drives `out_data`). A skid entry exists only with `PIPELINE_SKID_EN`.
- States: EMPTY (occ 0), FULL (occ 1), SKID (occ 2, macro only).
- EMPTY:
  - Transfer in → FULL; head ← `in_data`.
- FULL:
  - In and out together → FULL; head ← `in_data`.
  - Out only → EMPTY.
  - In only → SKID (skid ← `in_data`). This transition exists only with the macro.
  - Neither → hold.
- SKID:
  - `in_ready` = 0.
  - Out → FULL; head ← skid.
  - Otherwise hold.
- Priority at each edge: `reset` > `flush` > handshake.
  - `reset` or `flush` → EMPTY, `out_data` ← RESET_VALUE, `occupancy` ← 0.
  - Any input offered in that cycle is discarded, even if `in_ready` was 1.
- `out_data` is RESET_VALUE whenever EMPTY; stale payload is never exposed.
- `out_data` and `out_valid` are stable while `out_valid && !out_ready`. Data never changes under a stalled valid.
- No entry is dropped or duplicated; order is FIFO.

## Timing
- Reset values: `out_valid`=0, `out_data`=RESET_VALUE, `occupancy`=0.
- `in_ready` value while `reset` is high: 0 with the macro, 1 without.
- `in_ready` after reset: 1 in the first cycle after reset deasserts (both builds).
- Latency: data accepted at edge N is visible on `out_data` with `out_valid`=1 after edge N.
- Throughput: one transfer per cycle sustained when `out_ready`=1.
- With `PIPELINE_SKID_EN`:
  - `in_ready` = (state ≠ SKID), driven from flops only; no combinational path from `out_ready`.
- Without it:
  - `in_ready` = !`out_valid` || `out_ready` (combinational).
  - `flush` high forces `in_ready` = 0 combinationally.
- Flush during SKID clears both entries in one edge.
- Reset asserted mid-stall clears everything in one edge; there is no partial drain.

## Configuration
- `PIPELINE_SKID_EN` defined:
  - 2-entry storage, SKID state present.
  - Registered `in_ready`.
  - `occupancy` ranges 0..2.
- Undefined:
  - Single entry, states EMPTY/FULL only.
  - Combinational `in_ready` as above.
  - `occupancy` ≤ 1, bit 1 tied 0.
- Both builds: identical ordering, latency and flush/reset semantics.

## Test plan
- Reset/idle: WIDTH=64, hold `reset`=1 two cycles with `in_valid`=1, `in_data`=0xDEAD → `out_valid`=0, `out_data`=0, `occupancy`=0; first post-reset cycle `in_ready`=1.
- Streaming: `out_ready`=1, inputs 1,2,3,4 on consecutive cycles → outputs 1,2,3,4 one cycle later each, no bubbles.
- Stall:
  - Macro build: accept 0xA, then hold `out_ready`=0 while offering 0xB, 0xC → 0xB lands in skid, `in_ready`=0, `occupancy`=2, `out_data` held 0xA.
  - On release, drain order is 0xA, 0xB, then 0xC.
  - Non-macro build: 0xB waits upstream, `in_ready`=0 throughout the stall.
- Flush: SKID state holding 0x11/0x22, assert `flush` with `in_valid`=1, `in_data`=0x33 → next cycle EMPTY, `out_valid`=0, `out_data`=RESET_VALUE, 0x33 never appears.
- Reset priority: assert `reset` and `flush` together while FULL with `out_ready`=0 → EMPTY next cycle, same result as reset alone.
- Width sweep: WIDTH=1 and WIDTH=32 with RESET_VALUE=all ones → streaming passes; flush yields `out_data`=all ones.
